motoro3_ramp_ctrl: RTL and testbench

- Command stage directly upstream of motoro3_top; drives its m3start, m3freq and m3invOrStop inputs.
- Converts raw run/direction/frequency commands into a soft-start / soft-stop frequency ramp.
- Direction reversal is ordered: ramp down, stop, dead time, then restart in the new direction. The motor bridge never sees a step change in speed or an on-the-fly direction flip.
- Runs in the 10 MHz motor clock domain (clkM3).

---
 rtl/motoro3_ramp_ctrl_if.sv | 27 ++
 rtl/motoro3_ramp_ctrl.sv | 161 ++++++++++++++++
 tb/tb_motoro3_ramp_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/motoro3_ramp_ctrl_if.sv
// Command/drive bundle between the ramp controller and its neighbours.
// Latency: none (wires only).
// Backpressure: none; commands are levels and outputs are continuous drives.
interface motoro3_ramp_ctrl_if #(
  parameter int FREQ_W = 10
);
  // raw commands from the host side
  logic              cmdRun;
  logic              cmdDir;
  logic [FREQ_W-1:0] cmdFreq;
  // ramped drive towards motoro3_top plus status
  logic              m3start;
  logic [FREQ_W-1:0] m3freq;
  logic              m3invOrStop;
  logic              busy;
  logic              atSpeed;

  modport master (
    output cmdRun, cmdDir, cmdFreq,
    input  m3start, m3freq, m3invOrStop, busy, atSpeed
  );

  modport slave (
    input  cmdRun, cmdDir, cmdFreq,
    output m3start, m3freq, m3invOrStop, busy, atSpeed
  );
endinterface

// File: rtl/motoro3_ramp_ctrl.sv
// Soft-start / soft-stop frequency ramp with ordered direction reversal for motoro3_top.
// Latency: cmdRun to m3start is 1 cycle; m3freq moves 1 LSB per STEP_DIV cycles.
// Backpressure: none; commands are levels re-evaluated every cycle, all outputs registered.
module motoro3_ramp_ctrl #(
  parameter int FREQ_W      = 10,
  parameter int STEP_DIV    = 10000,
  parameter int FREQ_MIN    = 10,
  parameter int DEAD_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  motoro3_ramp_ctrl_if.slave   bus
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES);
  localparam logic [FREQ_W-1:0] F_MIN     = FREQ_W'(FREQ_MIN);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RAMP = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_DOWN = 3'd3;
  localparam logic [2:0] ST_DEAD = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              start_q, start_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              inv_q, inv_d;
  logic              busy_q, at_speed_q;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;

  logic [FREQ_W-1:0] tgt;
  logic              stop_req;
  logic              tick;

  // Effective target is clamped up to the start/stop frequency; a stop or a
  // direction change both mean "wind down" and are treated identically.
  always_comb begin
    tgt      = (bus.cmdFreq < F_MIN) ? F_MIN : bus.cmdFreq;
    stop_req = !bus.cmdRun || (bus.cmdDir != inv_q);
    tick     = (step_cnt_q == STEP_LAST);
  end

  // Next-state logic for the ramp sequencer and its step/dead timers.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    freq_d  = freq_q;
    inv_d   = inv_q;

    case (state_q)
      ST_IDLE: begin
        start_d = 1'b0;
        freq_d  = '0;
        // Direction is latched only here, so the bridge never sees a flip while enabled.
        if (bus.cmdRun) begin
          inv_d   = bus.cmdDir;
          freq_d  = F_MIN;
          start_d = 1'b1;
          state_d = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (stop_req) begin
          state_d = ST_DOWN;
        end else if (freq_q == tgt) begin
          state_d = ST_RUN;
        end else if (tick) begin
          // Steps only toward tgt, and tgt lies in [FREQ_MIN, 2^FREQ_W-1],
          // so neither direction can overshoot, underflow or wrap.
          if (tgt > freq_q) begin
            freq_d = freq_q + FREQ_W'(1);
          end else begin
            freq_d = freq_q - FREQ_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_DOWN;
        end else if (tgt != freq_q) begin
          state_d = ST_RAMP;
        end
      end
      ST_DOWN: begin
        if (!stop_req) begin
          // Run re-requested in the latched direction: climb from where we are.
          state_d = ST_RAMP;
        end else if (tick) begin
          if (freq_q > F_MIN) begin
            freq_d = freq_q - FREQ_W'(1);
          end else begin
            start_d = 1'b0;
            freq_d  = '0;
            state_d = ST_DEAD;
          end
        end
      end
      ST_DEAD: begin
        start_d = 1'b0;
        freq_d  = '0;
        if (dead_cnt_q == DEAD_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        start_d = 1'b0;
        freq_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Step timer runs only while ramping; any state change restarts it, which
    // also discards a tick that lands on a transition.
    step_cnt_d = '0;
    if ((state_d == state_q) && ((state_q == ST_RAMP) || (state_q == ST_DOWN)) && !tick) begin
      step_cnt_d = step_cnt_q + STEP_W'(1);
    end

    // Dead timer counts from zero on DEAD entry.
    dead_cnt_d = '0;
    if ((state_q == ST_DEAD) && (state_d == ST_DEAD)) begin
      dead_cnt_d = dead_cnt_q + DEAD_W'(1);
    end
  end

  // State, drive and status registers; status flags follow the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      freq_q     <= '0;
      inv_q      <= 1'b0;
      busy_q     <= 1'b0;
      at_speed_q <= 1'b0;
      step_cnt_q <= '0;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      freq_q     <= freq_d;
      inv_q      <= inv_d;
      busy_q     <= (state_d != ST_IDLE);
      at_speed_q <= (state_d == ST_RUN);
      step_cnt_q <= step_cnt_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  assign bus.m3start     = start_q;
  assign bus.m3freq      = freq_q;
  assign bus.m3invOrStop = inv_q;
  assign bus.busy        = busy_q;
  assign bus.atSpeed     = at_speed_q;

endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Bench for motoro3_ramp_ctrl: directed command sequence, per-cycle model compare
// plus hand-computed checkpoints from the test plan.
// Clock period 10; inputs change on the falling edge, outputs sampled there too.
module tb_motoro3_ramp_ctrl;

  localparam int FW   = 10;
  localparam int SD   = 4;
  localparam int FMIN = 10;
  localparam int DC   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motoro3_ramp_ctrl_if #(.FREQ_W(FW)) bus ();

  motoro3_ramp_ctrl #(
    .FREQ_W(FW), .STEP_DIV(SD), .FREQ_MIN(FMIN), .DEAD_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Modes: stopped, slewing toward target, cruising, braking to stop, cooling off.
  localparam int M_STOPPED = 0;
  localparam int M_SLEW    = 1;
  localparam int M_CRUISE  = 2;
  localparam int M_BRAKE   = 3;
  localparam int M_COOL    = 4;

  bit armed = 1'b0;
  int m_mode = M_STOPPED, m_start = 0, m_freq = 0, m_inv = 0, m_el = 0;

  always @(posedge clk) begin
    int tgt, md, st, fq, iv, el;
    bit wind_down;
    md = m_mode; st = m_start; fq = m_freq; iv = m_inv; el = m_el;
    tgt = (int'(bus.cmdFreq) < FMIN) ? FMIN : int'(bus.cmdFreq);
    wind_down = !bus.cmdRun || (int'(bus.cmdDir) != m_inv);
    if (rst) begin
      md = M_STOPPED; st = 0; fq = 0; iv = 0; el = 0;
      armed <= 1'b1;
    end else begin
      case (m_mode)
        M_STOPPED: if (bus.cmdRun) begin
          md = M_SLEW; st = 1; fq = FMIN; iv = int'(bus.cmdDir); el = 0;
        end
        M_SLEW: begin
          if (wind_down) begin md = M_BRAKE; el = 0; end
          else if (m_freq == tgt) begin md = M_CRUISE; el = 0; end
          else begin
            el = m_el + 1;
            if (el == SD) begin
              el = 0;
              fq = (tgt > m_freq) ? m_freq + 1 : m_freq - 1;
            end
          end
        end
        M_CRUISE: begin
          if (wind_down) begin md = M_BRAKE; el = 0; end
          else if (m_freq != tgt) begin md = M_SLEW; el = 0; end
        end
        M_BRAKE: begin
          if (!wind_down) begin md = M_SLEW; el = 0; end
          else begin
            el = m_el + 1;
            if (el == SD) begin
              el = 0;
              if (m_freq > FMIN) fq = m_freq - 1;
              else begin md = M_COOL; st = 0; fq = 0; end
            end
          end
        end
        default: begin
          // Stop-to-restart spacing: DC counted cycles plus the hand-back cycle.
          el = m_el + 1;
          if (el == DC + 1) begin md = M_STOPPED; el = 0; end
        end
      endcase
    end
    m_mode  <= md;
    m_start <= st;
    m_freq  <= fq;
    m_inv   <= iv;
    m_el    <= el;
  end

  // Every cycle after the first reset edge, all outputs must match the model.
  always @(negedge clk) begin
    if (armed) begin
      check("model.m3start", bus.m3start, m_start);
      check("model.m3freq", bus.m3freq, m_freq);
      check("model.m3invOrStop", bus.m3invOrStop, m_inv);
      check("model.busy", bus.busy, (m_mode != M_STOPPED) ? 1 : 0);
      check("model.atSpeed", bus.atSpeed, (m_mode == M_CRUISE) ? 1 : 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit hit(input int which);
    return (which == 0) ? (bus.atSpeed === 1'b1) : (bus.busy === 1'b0);
  endfunction

  // which: 0 = wait for atSpeed, 1 = wait for busy low
  task automatic wait_cond(input string nm, input int which, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!hit(which) && k < budget);
    if (!hit(which)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: condition not reached, got timeout after %0d cycles, expected reached", nm, k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmdRun  = 1'b0;
    bus.cmdDir  = 1'b0;
    bus.cmdFreq = '0;
    skip(2);
    check("rst.m3start", bus.m3start, 0);
    check("rst.m3freq", bus.m3freq, 0);
    check("rst.inv", bus.m3invOrStop, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.atSpeed", bus.atSpeed, 0);

    // Start toward 14
    rst = 1'b0; bus.cmdRun = 1'b1; bus.cmdDir = 1'b0; bus.cmdFreq = 10'd14;
    skip(1);
    check("start.m3start", bus.m3start, 1);
    check("start.m3freq", bus.m3freq, 10);
    check("start.inv", bus.m3invOrStop, 0);
    skip(3);  check("start.hold10", bus.m3freq, 10);
    skip(1);  check("start.f11", bus.m3freq, 11);
    skip(4);  check("start.f12", bus.m3freq, 12);
    skip(4);  check("start.f13", bus.m3freq, 13);
    skip(4);  check("start.f14", bus.m3freq, 14);
    check("start.notyet", bus.atSpeed, 0);
    skip(1);  check("start.atSpeed", bus.atSpeed, 1);

    // Stop from RUN@14
    bus.cmdRun = 1'b0;
    skip(1);  check("stop.f14", bus.m3freq, 14);
    check("stop.atSpeed0", bus.atSpeed, 0);
    skip(4);  check("stop.f13", bus.m3freq, 13);
    skip(12); check("stop.f10", bus.m3freq, 10);
    skip(4);  check("stop.m3start0", bus.m3start, 0);
    check("stop.f0", bus.m3freq, 0);
    skip(8);  check("stop.busy_dead", bus.busy, 1);
    skip(1);  check("stop.busy0", bus.busy, 0);

    // Reversal from RUN@12
    bus.cmdRun = 1'b1; bus.cmdFreq = 10'd12;
    wait_cond("rev.reach12", 0, 40);
    check("rev.f12", bus.m3freq, 12);
    bus.cmdDir = 1'b1;
    skip(12); check("rev.f10", bus.m3freq, 10);
    check("rev.inv_held", bus.m3invOrStop, 0);
    skip(1);  check("rev.m3start0", bus.m3start, 0);
    skip(8);  check("rev.dead_busy", bus.busy, 1);
    skip(1);  check("rev.idle", bus.busy, 0);
    check("rev.idle_start", bus.m3start, 0);
    skip(1);  check("rev.restart", bus.m3start, 1);
    check("rev.inv1", bus.m3invOrStop, 1);
    check("rev.fmin", bus.m3freq, 10);

    // Resume from DOWN at 12 with same direction
    wait_cond("res.reach12", 0, 40);
    bus.cmdRun = 1'b0;
    skip(1);  check("res.down", bus.atSpeed, 0);
    bus.cmdRun = 1'b1; bus.cmdFreq = 10'd14;
    skip(1);  check("res.nostop", bus.m3start, 1);
    check("res.f12", bus.m3freq, 12);
    skip(3);  check("res.hold12", bus.m3freq, 12);
    skip(1);  check("res.f13", bus.m3freq, 13);
    skip(4);  check("res.f14", bus.m3freq, 14);
    skip(1);  check("res.atSpeed", bus.atSpeed, 1);

    // Clamp low command to FREQ_MIN
    bus.cmdFreq = 10'd3;
    wait_cond("clamp.reach", 0, 40);
    check("clamp.f10", bus.m3freq, 10);
    skip(10); check("clamp.hold", bus.m3freq, 10);
    check("clamp.running", bus.m3start, 1);

    // Retarget to full scale and back
    bus.cmdFreq = 10'd1023;
    wait_cond("max.reach", 0, 5000);
    check("max.f1023", bus.m3freq, 1023);
    skip(8);  check("max.hold", bus.m3freq, 1023);
    check("max.running", bus.m3start, 1);
    bus.cmdFreq = 10'd1020;
    skip(5);  check("max.f1022", bus.m3freq, 1022);
    skip(8);  check("max.f1020", bus.m3freq, 1020);
    check("max.notyet", bus.atSpeed, 0);
    skip(1);  check("max.atSpeed", bus.atSpeed, 1);

    // Reset mid-ramp
    bus.cmdRun = 1'b0; bus.cmdDir = 1'b0;
    wait_cond("rstm.stopped", 1, 6000);
    bus.cmdRun = 1'b1; bus.cmdFreq = 10'd14;
    skip(1);  check("rstm.f10", bus.m3freq, 10);
    skip(8);  check("rstm.f12", bus.m3freq, 12);
    rst = 1'b1;
    skip(1);
    check("rstm.m3start", bus.m3start, 0);
    check("rstm.m3freq", bus.m3freq, 0);
    check("rstm.inv", bus.m3invOrStop, 0);
    check("rstm.busy", bus.busy, 0);
    check("rstm.atSpeed", bus.atSpeed, 0);
    rst = 1'b0;
    skip(1);  check("rstm.restart", bus.m3start, 1);
    check("rstm.fmin", bus.m3freq, 10);
    skip(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
